// File: rtl/bits_please_pkg.sv
// Shared types and constants for the score display path: FSM states,
// active-low seven-segment glyphs and default geometry.
package bits_please_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DIGITS = 8;

  // Active-low glyphs, bit 0 = segment a, bit 6 = segment g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment glyph.
module seg7_decoder
  import bits_please_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Iterative double-dabble binary-to-BCD converter driving active-low HEX digits.
// Optional leading-zero blanking is enabled with `define SCORE_DISPLAY_BLANK_EN.
module score_display
  import bits_please_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  value_load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   segments
);

  localparam int          CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int          BCD_W     = 4 * DIGITS;
  localparam logic [63:0] MAX_VALUE = pow10(DIGITS) - 64'd1;

  state_t                   state, state_next;
  logic [WIDTH-1:0]         bin;
  logic [BCD_W-1:0]         bcd, bcd_adj;
  logic [BCD_W+WIDTH-1:0]   shifted;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_flag;
  logic [7*DIGITS-1:0]      glyphs, seg_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value_load) state_next = SHIFT;
      SHIFT:   if (cnt == '0) state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // The top BCD bit falls off here; that only happens for masked overflow values
  assign shifted = {bcd_adj, bin} << 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (value_load) begin
          bin      <= value;
          bcd      <= '0;
          ovf_flag <= (64'(value) > MAX_VALUE);
          cnt      <= CNT_W'(WIDTH - 1);
        end
        SHIFT: begin
          bcd <= shifted[BCD_W+WIDTH-1:WIDTH];
          bin <= shifted[WIDTH-1:0];
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .bcd (bcd[4*g +: 4]),
      .seg (glyphs[7*g +: 7])
    );
  end

`ifdef SCORE_DISPLAY_BLANK_EN
  logic leading;
`endif

  always_comb begin
    seg_next = glyphs;
`ifdef SCORE_DISPLAY_BLANK_EN
    // Blank from the top down until the first non-zero digit; digit 0 always shows
    leading = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0) leading = 1'b0;
      if (leading) seg_next[7*i +: 7] = SEG_BLANK;
    end
`endif
    if (ovf_flag) seg_next = {DIGITS{SEG_DASH}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      segments <= {(7*DIGITS){1'b1}};
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == LATCH);
      if (state == LATCH) begin
        segments <= seg_next;
        overflow <= ovf_flag;
      end
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed test-plan steps plus random
// loads checked against a decimal-arithmetic reference model.
module tb_score_display;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic        value_load;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [55:0] segments;

  int errors = 0;
  int checks = 0;
  int cycles = 0;

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  score_display dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .value_load (value_load),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .segments   (segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: decimal digits by repeated division, then glyph lookup
  function automatic logic [55:0] model_segments(input logic [31:0] v);
    logic [55:0] s;
    longint unsigned n;
    int d [8];
    int msd;
    if (v > 32'd99999999) return {8{7'h3F}};
    n   = v;
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = int'(n % 10);
      n    = n / 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < 8; i++) begin
      s[7*i +: 7] = glyph[d[i]];
`ifdef SCORE_DISPLAY_BLANK_EN
      if (i > msd) s[7*i +: 7] = 7'h7F;
`endif
    end
    return s;
  endfunction

  // Called on a negedge; returns on the negedge after the sampling edge
  task automatic apply_stimulus(input logic [31:0] v);
    value      = v;
    value_load = 1'b1;
    @(negedge clk);
    value_load = 1'b0;
    cycles     = 0;
  endtask

  task automatic wait_done();
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] v);
    check_output({tag, "_latency"}, 64'(cycles), 64'd33);
    check_output({tag, "_done"}, 64'(done), 64'd1);
    check_output({tag, "_busy_low"}, 64'(busy), 64'd0);
    check_output({tag, "_segments"}, 64'(segments), 64'(model_segments(v)));
    check_output({tag, "_overflow"}, 64'(overflow), 64'(v > 32'd99999999));
  endtask

  initial begin
    logic [31:0] v;
    int activity;

    rst        = 1'b0;
    value      = '0;
    value_load = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_segments", 64'(segments), 64'(56'hFF_FFFF_FFFF_FFFF));
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_overflow", 64'(overflow), 64'd0);

    rst      = 1'b1;
    activity = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy || done) activity++;
    end
    check_output("idle_activity", 64'(activity), 64'd0);
    check_output("idle_segments", 64'(segments), 64'(56'hFF_FFFF_FFFF_FFFF));

    apply_stimulus(32'd12345678);
    check_output("busy_after_load", 64'(busy), 64'd1);
    wait_done();
    check_result("load_12345678", 32'd12345678);

    apply_stimulus(32'd99999999);
    wait_done();
    check_result("max_value", 32'd99999999);
    apply_stimulus(32'd100000000);
    wait_done();
    check_result("overflow_b2b", 32'd100000000);

    apply_stimulus(32'd5);
    repeat (9) @(negedge clk);
    value      = 32'd7;
    value_load = 1'b1;
    @(negedge clk);
    value_load = 1'b0;
    cycles     = cycles + 10;
    wait_done();
    check_result("ignored_load", 32'd5);
    activity = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) activity++;
    end
    check_output("single_done", 64'(activity), 64'd0);

    apply_stimulus(32'd42);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("abort_segments", 64'(segments), 64'(56'hFF_FFFF_FFFF_FFFF));
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    check_output("abort_overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    activity = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) activity++;
    end
    check_output("abort_no_done", 64'(activity), 64'd0);
    apply_stimulus(32'd0);
    wait_done();
    check_result("zero_after_reset", 32'd0);

    apply_stimulus(32'd42);
    wait_done();
    check_result("load_42", 32'd42);

    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) v = $urandom_range(99999999, 0);
      else            v = $urandom;
      @(negedge clk);
      apply_stimulus(v);
      wait_done();
      check_result($sformatf("random_%0d", i), v);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
